instr_loader: RTL and testbench

Boot-time program loader that writes the instruction memory feeding the single-cycle core's fetch/decode path. It accepts a byte stream (length header + little-endian instruction words) over a valid/ready handshake and writes one 32-bit word per write strobe. While loading it holds the core's `trigger` stall input high, so decode suppresses all register and memory writes and holds the PC. On completion it pulses a PC reset so the core restarts at address 0.

---
 rtl/loader_pkg.sv | 24 ++
 rtl/byte_assembler.sv | 46 ++++
 rtl/instr_loader.sv | 181 ++++++++++++++++++
 tb/tb_instr_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
//   Shared types and constants for the boot-time instruction loader.
//   - loader_state_t : FSM states of instr_loader
//   - BYTES_PER_WORD : stream bytes per 32-bit instruction word
//   - byte_idx_t     : index of a byte within a word
//   - word_t         : 32-bit instruction / header word
// -----------------------------------------------------------------------------
package loader_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef logic [1:0]  byte_idx_t;
    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        WRITE,
        DONE
    } loader_state_t;

endpackage

// File: rtl/byte_assembler.sv
// -----------------------------------------------------------------------------
// byte_assembler
//   Collects four stream bytes into one little-endian 32-bit word. The first
//   accepted byte ends up in bits [7:0].
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     clr        : restart assembly (byte index and word cleared)
//     accept     : a byte is transferred this cycle
//     byte_data  : the byte being transferred
//     word       : assembled word (complete the cycle after the 4th accept)
//     last_byte  : the next accepted byte completes a word
// -----------------------------------------------------------------------------
module byte_assembler
    import loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       accept,
    input  logic [7:0] byte_data,
    output word_t      word,
    output logic       last_byte
);

    byte_idx_t byte_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            word     <= '0;
        end else if (clr) begin
            byte_cnt <= '0;
            word     <= '0;
        end else if (accept) begin
            // Index wraps to 0 after the 4th byte, ready for the next word.
            byte_cnt <= byte_cnt + 1'b1;
            // Shift right so the earliest byte settles in the low lane.
            word     <= {byte_data, word[31:8]};
        end
    end

    assign last_byte = (byte_cnt == byte_idx_t'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//   Boot-time program loader for the instruction memory. Receives a byte
//   stream (32-bit word count N, then N little-endian words), writes one word
//   per imem_we strobe, stalls the core via trigger while loading and pulses
//   pc_reset on completion so the core restarts at address 0.
//   Ports:
//     clk, rst_n             : clock, asynchronous active-low reset
//     start                  : begin a load (honoured only when idle)
//     byte_valid/byte_data   : stream source
//     byte_ready             : loader accepts a byte this cycle
//     imem_we/addr/wdata     : instruction memory write port
//     trigger                : core stall request (high while loading)
//     pc_reset, done         : one-cycle completion pulses
//     err                    : sticky, header count exceeded capacity
// -----------------------------------------------------------------------------
module instr_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  trigger,
    output logic                  pc_reset,
    output logic                  done,
    output logic                  err
);

    localparam word_t CAPACITY = word_t'(1) << ADDR_WIDTH;

    loader_state_t state, state_nxt;

    // One extra bit so a full-capacity load never wraps the count.
    logic [ADDR_WIDTH:0] word_cnt;
    word_t               n_words;

    word_t asm_word;
    word_t hdr_word;
    logic  last_byte;
    logic  accept;
    logic  last_word;

    logic  asm_clr;
    logic  cnt_clr;
    logic  cnt_inc;
    logic  n_load;
    logic  err_set;
    logic  err_clr;

    byte_assembler u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (asm_clr),
        .accept    (accept),
        .byte_data (byte_data),
        .word      (asm_word),
        .last_byte (last_byte)
    );

    assign accept = byte_valid && byte_ready;

    // Header value as it will stand once the byte on the bus is taken, so the
    // range decision is made on the same edge as the 4th header byte.
    assign hdr_word = {byte_data, asm_word[31:8]};

    assign last_word = (word_t'(word_cnt) == n_words - word_t'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal written here gets a default first; a missed branch
    // would otherwise infer a latch.
    always_comb begin
        state_nxt  = state;
        asm_clr    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        n_load     = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        trigger    = 1'b1;
        pc_reset   = 1'b0;
        done       = 1'b0;

        case (state)
            IDLE: begin
                trigger = 1'b0;
                if (start) begin
                    state_nxt = HDR;
                    asm_clr   = 1'b1;
                    cnt_clr   = 1'b1;
                    err_clr   = 1'b1;
                end
            end
            HDR: begin
                byte_ready = 1'b1;
                if (accept && last_byte) begin
                    n_load = 1'b1;
                    if (hdr_word == '0) begin
                        state_nxt = DONE;
                    end else if (hdr_word > CAPACITY) begin
                        err_set   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                byte_ready = 1'b1;
                if (accept && last_byte) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                imem_we = 1'b1;
                if (last_word) begin
                    state_nxt = DONE;
                end else begin
                    cnt_inc   = 1'b1;
                    state_nxt = DATA;
                end
            end
            DONE: begin
                // Core is still stalled this cycle, so it does not advance
                // while its PC is being forced to 0.
                pc_reset  = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                trigger   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
            n_words  <= '0;
            err      <= 1'b0;
        end else begin
            if (cnt_clr) begin
                word_cnt <= '0;
            end else if (cnt_inc) begin
                word_cnt <= word_cnt + 1'b1;
            end

            if (n_load) begin
                n_words <= hdr_word;
            end

            if (err_clr) begin
                err <= 1'b0;
            end else if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    assign imem_addr  = word_cnt[ADDR_WIDTH-1:0];
    assign imem_wdata = asm_word;

endmodule

// File: tb/tb_instr_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_loader
//   Directed test of instr_loader with a small (4-word) memory. Expected writes
//   are queued as each word is sent; a negedge monitor pops and compares them
//   whenever imem_we is seen.
// -----------------------------------------------------------------------------
module tb_instr_loader;
    import loader_pkg::*;

    localparam int AW = 2;

    typedef struct packed {
        logic [AW-1:0] addr;
        word_t         data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          trigger;
    logic          pc_reset;
    logic          done;
    logic          err;

    wr_t   exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    word_t prog [0:8];

    always #5 clk = ~clk;

    instr_loader #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .trigger    (trigger),
        .pc_reset   (pc_reset),
        .done       (done),
        .err        (err)
    );

    task automatic check(input string name, input word_t act, input word_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_bit({tag, "_byte_ready"}, byte_ready, 1'b0);
        check_bit({tag, "_imem_we"},    imem_we,    1'b0);
        check_bit({tag, "_trigger"},    trigger,    1'b0);
        check_bit({tag, "_pc_reset"},   pc_reset,   1'b0);
        check_bit({tag, "_done"},       done,       1'b0);
        check_bit({tag, "_err"},        err,        1'b0);
        check({tag, "_imem_addr"},  32'(imem_addr), 32'd0);
        check({tag, "_imem_wdata"}, imem_wdata,     32'd0);
    endtask

    // Present one byte from a negedge and hold it until the loader takes it.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check_bit("byte_accepted_in_time", byte_ready, 1'b1);
        if (byte_ready) begin
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input word_t w, input bit gaps);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], gaps ? int'($urandom_range(7, 1)) : 0);
        end
    endtask

    task automatic load_words(input int first, input int n, input bit gaps);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(wr_t'{AW'(k), prog[first + k]});
            send_word(prog[first + k], gaps);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called right after the last data byte was taken; returns the number of
    // negedges until done was seen, and checks the completion pulse shape.
    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 100);
        check_bit({tag, "_done"},     done,     1'b1);
        check_bit({tag, "_pc_reset"}, pc_reset, 1'b1);
        check_bit({tag, "_trigger"},  trigger,  1'b1);
        @(negedge clk);
        check_bit({tag, "_done_one_cycle"},     done,     1'b0);
        check_bit({tag, "_pc_reset_one_cycle"}, pc_reset, 1'b0);
        check_bit({tag, "_trigger_released"},   trigger,  1'b0);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (imem_we) begin
            check_bit("byte_ready_low_in_write", byte_ready, 1'b0);
            check_bit("trigger_high_in_write",   trigger,    1'b1);
            check_bit("write_was_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("write_addr", 32'(imem_addr), 32'(e.addr));
                check("write_data", imem_wdata,     e.data);
            end
        end
        if (done || pc_reset) begin
            check_bit("done_matches_pc_reset", done,    pc_reset);
            check_bit("trigger_high_in_done",  trigger, 1'b1);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at 200000 ns");
        $fatal(1);
    end

    initial begin : stimulus
        int cyc;

        prog[0] = 32'h0010_0513;
        prog[1] = 32'h0020_0593;
        prog[2] = 32'hDEAD_BEEF;
        prog[3] = 32'h1234_5678;
        prog[4] = 32'h0000_0013;
        prog[5] = 32'hA5A5_5A5A;
        prog[6] = 32'h0050_0093;
        prog[7] = 32'h0010_8113;
        prog[8] = 32'h0020_81B3;

        rst_n      = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // N=2, gap-free.
        pulse_start();
        @(negedge clk);
        check_bit("n2_trigger_after_start", trigger,    1'b1);
        check_bit("n2_ready_in_hdr",        byte_ready, 1'b1);
        send_word(32'd2, 1'b0);
        load_words(0, 2, 1'b0);
        wait_done("n2", cyc);
        check("n2_done_latency", 32'(cyc), 32'd2);
        check("n2_writes_pending", 32'(exp_q.size()), 32'd0);

        // N=0: straight to DONE the cycle after the 4th header byte.
        pulse_start();
        send_word(32'd0, 1'b0);
        @(negedge clk);
        check_bit("n0_done",     done,     1'b1);
        check_bit("n0_pc_reset", pc_reset, 1'b1);
        @(negedge clk);
        check_bit("n0_trigger_released", trigger, 1'b0);
        check_bit("n0_done_one_cycle",   done,    1'b0);

        // N=5 exceeds the 4-word memory.
        pulse_start();
        send_word(32'd5, 1'b0);
        @(negedge clk);
        check_bit("n5_err",        err,        1'b1);
        check_bit("n5_trigger",    trigger,    1'b0);
        check_bit("n5_byte_ready", byte_ready, 1'b0);
        check_bit("n5_no_done",    done,       1'b0);
        repeat (3) @(negedge clk);
        check_bit("n5_err_sticky", err, 1'b1);

        // A new start clears err; N=4 fills the memory.
        pulse_start();
        @(negedge clk);
        check_bit("n4_err_cleared", err,     1'b0);
        check_bit("n4_trigger",     trigger, 1'b1);
        send_word(32'd4, 1'b0);
        load_words(2, 4, 1'b0);
        wait_done("n4", cyc);
        check("n4_writes_pending", 32'(exp_q.size()), 32'd0);

        // N=3 with random byte_valid gaps.
        pulse_start();
        send_word(32'd3, 1'b1);
        load_words(6, 3, 1'b1);
        wait_done("n3gap", cyc);
        check("n3gap_done_latency", 32'(cyc), 32'd2);
        check("n3gap_writes_pending", 32'(exp_q.size()), 32'd0);

        // Reset after 6 data bytes: first word kept, everything else aborted.
        pulse_start();
        send_word(32'd2, 1'b0);
        exp_q.push_back(wr_t'{AW'(0), prog[0]});
        send_word(prog[0], 1'b0);
        send_byte(prog[1][7:0], 0);
        send_byte(prog[1][15:8], 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midload_reset");
        check("midload_first_word_written", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // start re-pulsed mid-load is ignored.
        pulse_start();
        send_word(32'd2, 1'b0);
        exp_q.push_back(wr_t'{AW'(0), prog[0]});
        send_byte(prog[0][7:0], 0);
        send_byte(prog[0][15:8], 0);
        pulse_start();
        send_byte(prog[0][23:16], 0);
        send_byte(prog[0][31:24], 0);
        exp_q.push_back(wr_t'{AW'(1), prog[1]});
        send_word(prog[1], 1'b0);
        wait_done("restart", cyc);
        check("restart_done_latency", 32'(cyc), 32'd2);
        check("restart_writes_pending", 32'(exp_q.size()), 32'd0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
